decode_inst_buffer: RTL and testbench
=====================================

Name: decode_inst_buffer

Overview:
- Per-warp instruction buffer directly downstream of the decode stage.
- Each cycle it accepts up to two decoded packets for one warp and queues them in program order, in a per-warp circular FIFO.
- It returns one packet per cycle to the issue stage for the warp that issue selects.
- It gives fetch/decode a per-warp ready signal and lets branch resolution flush one warp.

Parameters:
- NUM_WARP, 8, number of warps; power of 2.
- NUM_WARP_LOG, 3, log2(NUM_WARP).
- DEPTH, 4, entries per warp FIFO; power of 2, at least 2.
- DEPTH_LOG, 2, log2(DEPTH).
- PKT_W, 160, width of one decoded packet.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  active-low asynchronous reset.
- decodedWarp_i  in  NUM_WARP_LOG  warp that owns this cycle's decoded packets.
- decodedPacket0Valid_i  in  1  packet 0 valid.
- decodedPacket0_i  in  PKT_W  older decoded packet.
- decodedPacket1Valid_i  in  1  packet 1 valid.
- decodedPacket1_i  in  PKT_W  younger decoded packet.
- issueReq_i  in  1  issue requests a pop.
- issueWarp_i  in  NUM_WARP_LOG  warp to pop.
- flush_i  in  1  flush one warp's FIFO.
- flushWarp_i  in  NUM_WARP_LOG  warp to flush.
- warpReady_o  out  NUM_WARP  bit w=1 when warp w has 2 or more free entries.
- warpEmpty_o  out  NUM_WARP  bit w=1 when warp w holds 0 entries.
- issuePacketValid_o  out  1  registered; a packet is present on issuePacket_o.
- issuePacket_o  out  PKT_W  registered popped packet.
- issuePacketWarp_o  out  NUM_WARP_LOG  registered warp of the popped packet.
- overflowErr_o  out  1  registered one-cycle pulse when a write group is rejected.

Behaviour:
- Reset (reset=0, asynchronous):
  - all read pointers, write pointers and counts go to 0;
  - warpReady_o is all 1s and warpEmpty_o is all 1s;
  - issuePacketValid_o=0, issuePacket_o=0, issuePacketWarp_o=0, overflowErr_o=0;
  - FIFO storage is not reset.
- Per warp state: rdPtr and wrPtr are DEPTH_LOG bits and wrap modulo DEPTH; count is DEPTH_LOG+1 bits, range 0..DEPTH.
- Write group:
  - wcnt = decodedPacket0Valid_i + decodedPacket1Valid_i.
  - Packet1 valid without packet0 is legal; packet1 is then written alone.
  - If wcnt is at or below free(w) after this cycle's pop of the same warp is credited, the write is accepted.
  - On accept: packet0 goes to wrPtr, packet1 to wrPtr+1 (or to wrPtr if packet0 is invalid); wrPtr += wcnt.
  - Otherwise the whole group is dropped, no state changes, and overflowErr_o=1 on the next cycle.
- Pop:
  - If issueReq_i=1 and count(issueWarp_i) is above 0 before this cycle's writes, the head entry is latched into issuePacket_o, issuePacketValid_o=1 and issuePacketWarp_o=issueWarp_i on the next cycle; rdPtr += 1.
  - A pop on an empty warp gives issuePacketValid_o=0 next cycle. There is no write-to-read bypass.
  - issuePacketValid_o drops to 0 on any cycle with no successful pop; issuePacket_o keeps its last value.
- Same warp, pop and write in one cycle: count_next = count - pop + wcnt. When full with a pop, a single write (wcnt=1) is accepted.
- Flush:
  - flush_i clears count, rdPtr and wrPtr of flushWarp_i to 0.
  - Flush has priority over both write and pop to that warp in the same cycle: write dropped (no overflowErr_o), pop returns invalid.
  - Other warps are unaffected.
- warpReady_o and warpEmpty_o are combinational from the registered counts: ready means count is DEPTH-2 or less; empty means count is 0.
- Latency: write to earliest possible pop is 1 cycle; pop to issuePacket_o is 1 cycle.
- Reset asserted mid-operation discards all queued packets; after release the block behaves as after power-on.

Test Plan:
- After reset, write warp 3 with packets A,B (both valid). Pop warp 3 for 2 cycles -> issuePacket_o shows A then B, issuePacketWarp_o=3, warpEmpty_o[3]=1 afterwards.
- Write warp 5 with 2-packet groups for 2 cycles (DEPTH=4) -> warpReady_o[5]=0, warpEmpty_o[5]=0. A third 2-packet group -> dropped, overflowErr_o pulses for 1 cycle, count stays 4.
- Warp 5 full; in the same cycle pop warp 5 and write packet1 only (C) -> accepted, count stays 4; C pops after the 4 older entries.
- Fill warp 2 so the pointers wrap (4 writes, 3 pops, 3 writes) -> pop order matches write order across the wrap.
- In one cycle flush warp 1 while writing and popping warp 1 -> next cycle warpEmpty_o[1]=1, issuePacketValid_o=0, overflowErr_o=0; warp 0 contents intact.
- Pop on an empty warp -> issuePacketValid_o=0. Assert reset with entries queued in 3 warps -> all warpEmpty_o=1 and issuePacketValid_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/decode_inst_buffer.sv
// Per-warp circular instruction FIFOs between decode and issue.
// Accepts up to two decoded packets per cycle for one warp and pops one packet per cycle for issue.
module decode_inst_buffer #(
    parameter int NUM_WARP     = 8,
    parameter int NUM_WARP_LOG = 3,
    parameter int DEPTH        = 4,
    parameter int DEPTH_LOG    = 2,
    parameter int PKT_W        = 160
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_WARP_LOG-1:0] decodedWarp_i,
    input  logic                    decodedPacket0Valid_i,
    input  logic [PKT_W-1:0]        decodedPacket0_i,
    input  logic                    decodedPacket1Valid_i,
    input  logic [PKT_W-1:0]        decodedPacket1_i,
    input  logic                    issueReq_i,
    input  logic [NUM_WARP_LOG-1:0] issueWarp_i,
    input  logic                    flush_i,
    input  logic [NUM_WARP_LOG-1:0] flushWarp_i,
    output logic [NUM_WARP-1:0]     warpReady_o,
    output logic [NUM_WARP-1:0]     warpEmpty_o,
    output logic                    issuePacketValid_o,
    output logic [PKT_W-1:0]        issuePacket_o,
    output logic [NUM_WARP_LOG-1:0] issuePacketWarp_o,
    output logic                    overflowErr_o
);

    typedef logic [DEPTH_LOG-1:0]    ptr_t;
    typedef logic [DEPTH_LOG:0]      cnt_t;
    typedef logic [DEPTH_LOG+1:0]    free_t;
    typedef logic [NUM_WARP_LOG-1:0] warp_t;

    logic [PKT_W-1:0] mem [NUM_WARP][DEPTH];
    ptr_t             rdPtr [NUM_WARP];
    ptr_t             wrPtr [NUM_WARP];
    cnt_t             count [NUM_WARP];

    logic [1:0] wcnt;
    logic       popHit;
    logic       popSame;
    logic       wrFlushed;
    logic       wrFits;
    logic       wrOk;
    logic       wrReject;
    free_t      freeSlots;
    ptr_t       slot1;

    always_comb begin
        wcnt      = {1'b0, decodedPacket0Valid_i} + {1'b0, decodedPacket1Valid_i};
        popHit    = issueReq_i && (count[issueWarp_i] != '0)
                    && !(flush_i && (flushWarp_i == issueWarp_i));
        popSame   = popHit && (issueWarp_i == decodedWarp_i);
        wrFlushed = flush_i && (flushWarp_i == decodedWarp_i);
        // A same-cycle pop of the written warp frees one slot for this write group.
        freeSlots = free_t'(DEPTH) - free_t'(count[decodedWarp_i]) + free_t'(popSame);
        wrFits    = free_t'(wcnt) <= freeSlots;
        wrOk      = (wcnt != 2'd0) && !wrFlushed && wrFits;
        wrReject  = (wcnt != 2'd0) && !wrFlushed && !wrFits;
        slot1     = wrPtr[decodedWarp_i] + ptr_t'(decodedPacket0Valid_i);
    end

    always_comb begin
        warpReady_o = '0;
        warpEmpty_o = '0;
        for (int unsigned w = 0; w < NUM_WARP; w++) begin
            warpReady_o[w] = count[w] <= cnt_t'(DEPTH - 2);
            warpEmpty_o[w] = count[w] == '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wrOk) begin
            if (decodedPacket0Valid_i) mem[decodedWarp_i][wrPtr[decodedWarp_i]] <= decodedPacket0_i;
            if (decodedPacket1Valid_i) mem[decodedWarp_i][slot1] <= decodedPacket1_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned w = 0; w < NUM_WARP; w++) begin
                rdPtr[w] <= '0;
                wrPtr[w] <= '0;
                count[w] <= '0;
            end
        end else begin
            for (int unsigned w = 0; w < NUM_WARP; w++) begin
                if (flush_i && (flushWarp_i == warp_t'(w))) begin
                    rdPtr[w] <= '0;
                    wrPtr[w] <= '0;
                    count[w] <= '0;
                end else begin
                    logic popW;
                    logic wrW;
                    popW = popHit && (issueWarp_i == warp_t'(w));
                    wrW  = wrOk && (decodedWarp_i == warp_t'(w));
                    rdPtr[w] <= rdPtr[w] + ptr_t'(popW);
                    wrPtr[w] <= wrPtr[w] + (wrW ? ptr_t'(wcnt) : '0);
                    count[w] <= count[w] - cnt_t'(popW) + (wrW ? cnt_t'(wcnt) : '0);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issuePacketValid_o <= 1'b0;
            issuePacket_o      <= '0;
            issuePacketWarp_o  <= '0;
            overflowErr_o      <= 1'b0;
        end else begin
            issuePacketValid_o <= popHit;
            overflowErr_o      <= wrReject;
            if (popHit) begin
                issuePacket_o     <= mem[issueWarp_i][rdPtr[issueWarp_i]];
                issuePacketWarp_o <= issueWarp_i;
            end
        end
    end

endmodule

// File: tb/tb_decode_inst_buffer.sv
// Self-checking bench for decode_inst_buffer using a per-warp queue model and a pop scoreboard.
module tb_decode_inst_buffer;

    localparam int NUM_WARP     = 8;
    localparam int NUM_WARP_LOG = 3;
    localparam int DEPTH        = 4;
    localparam int DEPTH_LOG    = 2;
    localparam int PKT_W        = 160;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_WARP_LOG-1:0] decodedWarp;
    logic                    pkt0Valid;
    logic [PKT_W-1:0]        pkt0;
    logic                    pkt1Valid;
    logic [PKT_W-1:0]        pkt1;
    logic                    issueReq;
    logic [NUM_WARP_LOG-1:0] issueWarp;
    logic                    flush;
    logic [NUM_WARP_LOG-1:0] flushWarp;
    logic [NUM_WARP-1:0]     warpReady_o;
    logic [NUM_WARP-1:0]     warpEmpty_o;
    logic                    issuePacketValid_o;
    logic [PKT_W-1:0]        issuePacket_o;
    logic [NUM_WARP_LOG-1:0] issuePacketWarp_o;
    logic                    overflowErr_o;

    int nChecks = 0;
    int nErrors = 0;

    logic [PKT_W-1:0]        mq [NUM_WARP][$];
    logic [PKT_W-1:0]        sbPkt [$];
    logic [NUM_WARP_LOG-1:0] sbWarp [$];
    logic                    expValid;
    logic                    expOvf;
    logic [PKT_W-1:0]        expPkt;
    logic [NUM_WARP_LOG-1:0] expWarp;

    decode_inst_buffer #(
        .NUM_WARP(NUM_WARP), .NUM_WARP_LOG(NUM_WARP_LOG),
        .DEPTH(DEPTH), .DEPTH_LOG(DEPTH_LOG), .PKT_W(PKT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .decodedWarp_i(decodedWarp),
        .decodedPacket0Valid_i(pkt0Valid), .decodedPacket0_i(pkt0),
        .decodedPacket1Valid_i(pkt1Valid), .decodedPacket1_i(pkt1),
        .issueReq_i(issueReq), .issueWarp_i(issueWarp),
        .flush_i(flush), .flushWarp_i(flushWarp),
        .warpReady_o(warpReady_o), .warpEmpty_o(warpEmpty_o),
        .issuePacketValid_o(issuePacketValid_o), .issuePacket_o(issuePacket_o),
        .issuePacketWarp_o(issuePacketWarp_o), .overflowErr_o(overflowErr_o)
    );

    always #5 clk = ~clk;

    function automatic logic [PKT_W-1:0] mk(input int id);
        logic [31:0] s;
        s = 32'(id) ^ 32'h5A5A_0000;
        return {s, ~s, s + 32'd7, s ^ 32'h0F0F_0F0F, s};
    endfunction

    // Drives one cycle, updates the reference queues and scoreboard, samples 1 time unit after the edge.
    task automatic step(input logic [2:0] dw, input logic v0, input logic [PKT_W-1:0] p0,
                        input logic v1, input logic [PKT_W-1:0] p1,
                        input logic req, input logic [2:0] iw,
                        input logic fl, input logic [2:0] fw);
        int wc, freeN;
        bit popOk, popSame, flushed, acc;
        decodedWarp = dw; pkt0Valid = v0; pkt0 = p0; pkt1Valid = v1; pkt1 = p1;
        issueReq = req; issueWarp = iw; flush = fl; flushWarp = fw;
        popOk = req && (mq[iw].size() > 0) && !(fl && fw == iw);
        if (popOk) begin
            sbPkt.push_back(mq[iw][0]);
            sbWarp.push_back(iw);
        end
        wc      = int'(v0) + int'(v1);
        flushed = fl && (fw == dw);
        popSame = popOk && (iw == dw);
        freeN   = DEPTH - mq[dw].size() + int'(popSame);
        acc     = (wc > 0) && !flushed && (wc <= freeN);
        expOvf  = (wc > 0) && !flushed && !acc;
        if (popOk) void'(mq[iw].pop_front());
        if (fl) mq[fw].delete();
        if (acc) begin
            if (v0) mq[dw].push_back(p0);
            if (v1) mq[dw].push_back(p1);
        end
        @(posedge clk);
        #1;
        expValid = popOk;
        if (popOk) begin
            expPkt  = sbPkt.pop_front();
            expWarp = sbWarp.pop_front();
        end
    endtask

    task automatic wr2(input logic [2:0] w, input logic [PKT_W-1:0] a, input logic [PKT_W-1:0] b);
        step(w, 1'b1, a, 1'b1, b, 1'b0, 3'd0, 1'b0, 3'd0);
    endtask

    task automatic pop(input logic [2:0] w);
        step(3'd0, 1'b0, '0, 1'b0, '0, 1'b1, w, 1'b0, 3'd0);
    endtask

    task automatic idle();
        step(3'd0, 1'b0, '0, 1'b0, '0, 1'b0, 3'd0, 1'b0, 3'd0);
    endtask

    task automatic test_reset();
        nChecks++; if (issuePacketValid_o !== 1'b0) begin nErrors++; $display("FAIL reset_valid: got %b expected 0", issuePacketValid_o); end
        nChecks++; if (issuePacket_o !== '0) begin nErrors++; $display("FAIL reset_pkt: got %h expected 0", issuePacket_o); end
        nChecks++; if (issuePacketWarp_o !== 3'd0) begin nErrors++; $display("FAIL reset_warp: got %0d expected 0", issuePacketWarp_o); end
        nChecks++; if (overflowErr_o !== 1'b0) begin nErrors++; $display("FAIL reset_ovf: got %b expected 0", overflowErr_o); end
        nChecks++; if (warpReady_o !== 8'hFF) begin nErrors++; $display("FAIL reset_ready: got %h expected ff", warpReady_o); end
        nChecks++; if (warpEmpty_o !== 8'hFF) begin nErrors++; $display("FAIL reset_empty: got %h expected ff", warpEmpty_o); end
    endtask

    task automatic test_basic();
        wr2(3'd3, mk(1), mk(2));
        nChecks++; if (warpEmpty_o[3] !== 1'b0) begin nErrors++; $display("FAIL basic_notempty: got %b expected 0", warpEmpty_o[3]); end
        pop(3'd3);
        nChecks++; if (issuePacketValid_o !== 1'b1) begin nErrors++; $display("FAIL basic_valid0: got %b expected 1", issuePacketValid_o); end
        nChecks++; if (issuePacket_o !== mk(1)) begin nErrors++; $display("FAIL basic_pktA: got %h expected %h", issuePacket_o, mk(1)); end
        nChecks++; if (issuePacketWarp_o !== 3'd3) begin nErrors++; $display("FAIL basic_warp: got %0d expected 3", issuePacketWarp_o); end
        pop(3'd3);
        nChecks++; if (issuePacket_o !== mk(2) || issuePacketValid_o !== 1'b1) begin nErrors++; $display("FAIL basic_pktB: got %h/%b expected %h/1", issuePacket_o, issuePacketValid_o, mk(2)); end
        nChecks++; if (warpEmpty_o[3] !== 1'b1) begin nErrors++; $display("FAIL basic_empty: got %b expected 1", warpEmpty_o[3]); end
        idle();
        nChecks++; if (issuePacketValid_o !== 1'b0) begin nErrors++; $display("FAIL basic_idle_valid: got %b expected 0", issuePacketValid_o); end
    endtask

    task automatic test_overflow();
        wr2(3'd5, mk(11), mk(12));
        nChecks++; if (warpReady_o[5] !== 1'b1) begin nErrors++; $display("FAIL ovf_ready_half: got %b expected 1", warpReady_o[5]); end
        wr2(3'd5, mk(13), mk(14));
        nChecks++; if (warpReady_o[5] !== 1'b0 || warpEmpty_o[5] !== 1'b0) begin nErrors++; $display("FAIL ovf_full_flags: got ready %b empty %b expected 0 0", warpReady_o[5], warpEmpty_o[5]); end
        wr2(3'd5, mk(15), mk(16));
        nChecks++; if (overflowErr_o !== expOvf || overflowErr_o !== 1'b1) begin nErrors++; $display("FAIL ovf_pulse: got %b expected 1", overflowErr_o); end
        idle();
        nChecks++; if (overflowErr_o !== 1'b0) begin nErrors++; $display("FAIL ovf_pulse_end: got %b expected 0", overflowErr_o); end
        nChecks++; if (warpReady_o[5] !== 1'b0) begin nErrors++; $display("FAIL ovf_still_full: got %b expected 0", warpReady_o[5]); end
    endtask

    task automatic test_full_pop_write();
        logic [PKT_W-1:0] want [5];
        want = '{mk(11), mk(12), mk(13), mk(14), mk(20)};
        step(3'd5, 1'b0, '0, 1'b1, mk(20), 1'b1, 3'd5, 1'b0, 3'd0);
        nChecks++; if (overflowErr_o !== 1'b0) begin nErrors++; $display("FAIL fpw_no_ovf: got %b expected 0", overflowErr_o); end
        nChecks++; if (warpReady_o[5] !== 1'b0 || warpEmpty_o[5] !== 1'b0) begin nErrors++; $display("FAIL fpw_count4: got ready %b empty %b expected 0 0", warpReady_o[5], warpEmpty_o[5]); end
        nChecks++; if (issuePacketValid_o !== 1'b1 || issuePacket_o !== want[0]) begin nErrors++; $display("FAIL fpw_pop0: got %h/%b expected %h/1", issuePacket_o, issuePacketValid_o, want[0]); end
        for (int i = 1; i < 5; i++) begin
            pop(3'd5);
            nChecks++; if (issuePacketValid_o !== 1'b1 || issuePacket_o !== want[i] || issuePacket_o !== expPkt) begin nErrors++; $display("FAIL fpw_pop%0d: got %h expected %h", i, issuePacket_o, want[i]); end
        end
        nChecks++; if (warpEmpty_o[5] !== 1'b1) begin nErrors++; $display("FAIL fpw_empty: got %b expected 1", warpEmpty_o[5]); end
    endtask

    task automatic test_wrap();
        logic [PKT_W-1:0] want [7];
        for (int i = 0; i < 7; i++) want[i] = mk(30 + i);
        wr2(3'd2, want[0], want[1]);
        wr2(3'd2, want[2], want[3]);
        for (int i = 0; i < 3; i++) begin
            pop(3'd2);
            nChecks++; if (issuePacket_o !== want[i] || issuePacketValid_o !== 1'b1) begin nErrors++; $display("FAIL wrap_pre%0d: got %h expected %h", i, issuePacket_o, want[i]); end
        end
        wr2(3'd2, want[4], want[5]);
        step(3'd2, 1'b1, want[6], 1'b0, '0, 1'b0, 3'd0, 1'b0, 3'd0);
        nChecks++; if (overflowErr_o !== 1'b0 || warpReady_o[2] !== 1'b0) begin nErrors++; $display("FAIL wrap_full: got ovf %b ready %b expected 0 0", overflowErr_o, warpReady_o[2]); end
        for (int i = 3; i < 7; i++) begin
            pop(3'd2);
            nChecks++; if (issuePacket_o !== want[i] || issuePacketWarp_o !== 3'd2) begin nErrors++; $display("FAIL wrap_post%0d: got %h w%0d expected %h w2", i, issuePacket_o, issuePacketWarp_o, want[i]); end
        end
    endtask

    task automatic test_flush();
        wr2(3'd0, mk(40), mk(41));
        wr2(3'd1, mk(50), mk(51));
        wr2(3'd1, mk(52), mk(53));
        step(3'd1, 1'b1, mk(54), 1'b1, mk(55), 1'b1, 3'd1, 1'b1, 3'd1);
        nChecks++; if (warpEmpty_o[1] !== 1'b1 || warpReady_o[1] !== 1'b1) begin nErrors++; $display("FAIL flush_empty: got empty %b ready %b expected 1 1", warpEmpty_o[1], warpReady_o[1]); end
        nChecks++; if (issuePacketValid_o !== 1'b0) begin nErrors++; $display("FAIL flush_valid: got %b expected 0", issuePacketValid_o); end
        nChecks++; if (overflowErr_o !== 1'b0) begin nErrors++; $display("FAIL flush_ovf: got %b expected 0", overflowErr_o); end
        nChecks++; if (warpEmpty_o[0] !== 1'b0) begin nErrors++; $display("FAIL flush_other: got %b expected 0", warpEmpty_o[0]); end
        pop(3'd0);
        nChecks++; if (issuePacket_o !== mk(40) || issuePacketWarp_o !== 3'd0) begin nErrors++; $display("FAIL flush_w0a: got %h expected %h", issuePacket_o, mk(40)); end
        pop(3'd0);
        nChecks++; if (issuePacket_o !== mk(41) || issuePacketValid_o !== expValid) begin nErrors++; $display("FAIL flush_w0b: got %h expected %h", issuePacket_o, mk(41)); end
    endtask

    task automatic test_empty_pop();
        pop(3'd6);
        nChecks++; if (issuePacketValid_o !== 1'b0) begin nErrors++; $display("FAIL emptypop_valid: got %b expected 0", issuePacketValid_o); end
        nChecks++; if (issuePacket_o !== mk(41)) begin nErrors++; $display("FAIL emptypop_hold: got %h expected %h", issuePacket_o, mk(41)); end
    endtask

    task automatic test_reset_mid();
        wr2(3'd0, mk(60), mk(61));
        wr2(3'd4, mk(62), mk(63));
        wr2(3'd7, mk(64), mk(65));
        pop(3'd4);
        nChecks++; if (issuePacketValid_o !== 1'b1 || issuePacket_o !== mk(62)) begin nErrors++; $display("FAIL rmid_prepop: got %h/%b expected %h/1", issuePacket_o, issuePacketValid_o, mk(62)); end
        reset = 1'b0;
        #1;
        nChecks++; if (warpEmpty_o !== 8'hFF) begin nErrors++; $display("FAIL rmid_empty: got %h expected ff", warpEmpty_o); end
        nChecks++; if (warpReady_o !== 8'hFF) begin nErrors++; $display("FAIL rmid_ready: got %h expected ff", warpReady_o); end
        nChecks++; if (issuePacketValid_o !== 1'b0 || issuePacket_o !== '0) begin nErrors++; $display("FAIL rmid_out: got %h/%b expected 0/0", issuePacket_o, issuePacketValid_o); end
        decodedWarp = '0; pkt0Valid = 1'b0; pkt1Valid = 1'b0; issueReq = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int w = 0; w < NUM_WARP; w++) mq[w].delete();
        sbPkt.delete();
        sbWarp.delete();
        step(3'd0, 1'b1, mk(70), 1'b0, '0, 1'b0, 3'd0, 1'b0, 3'd0);
        pop(3'd0);
        nChecks++; if (issuePacket_o !== mk(70) || issuePacketValid_o !== 1'b1) begin nErrors++; $display("FAIL rmid_after: got %h/%b expected %h/1", issuePacket_o, issuePacketValid_o, mk(70)); end
        pop(3'd0);
        nChecks++; if (issuePacketValid_o !== 1'b0 || warpEmpty_o[0] !== 1'b1) begin nErrors++; $display("FAIL rmid_drained: got valid %b empty %b expected 0 1", issuePacketValid_o, warpEmpty_o[0]); end
    endtask

    initial begin
        reset = 1'b0;
        decodedWarp = '0; pkt0Valid = 1'b0; pkt0 = '0; pkt1Valid = 1'b0; pkt1 = '0;
        issueReq = 1'b0; issueWarp = '0; flush = 1'b0; flushWarp = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b1;
        test_basic();
        test_overflow();
        test_full_pop_write();
        test_wrap();
        test_flush();
        test_empty_pop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
